// File: rtl/alu_pipe_pkg.sv
// Shared types and constants for the ALU issue/writeback pipeline stage.
package alu_pipe_pkg;

   localparam int ALU_N    = 32;
   localparam int ALU_RA_W = 4;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_SUB  = 2'b01;
   localparam logic [1:0] ALU_MUL  = 2'b10;
   localparam logic [1:0] ALU_RSVD = 2'b11;

   // Contents of the issue register: everything the ALU needs plus the
   // destination index that travels on to writeback.
   typedef struct packed {
      logic [1:0]          sel;
      logic [ALU_RA_W-1:0] rd;
      logic [ALU_N-1:0]    op1;
      logic [ALU_N-1:0]    op2;
   } iss_t;

endpackage

// File: rtl/alu_issue_wb_stage_fwd_sel.sv
// Forwarding mux for one source operand. Register 0 is never forwarded.
// The ISS producer is newer than the WB producer, so it takes priority.
module fwd_sel
   import alu_pipe_pkg::*;
#(
   parameter int W     = 32,
   parameter int IDX_W = 4
) (
   input  logic [IDX_W-1:0] idx,
   input  logic [W-1:0]     rf_val,
   input  logic             iss_valid,
   input  logic [IDX_W-1:0] iss_rd,
   input  logic [W-1:0]     iss_val,
   input  logic             iss_adv,
   input  logic             wb_valid,
   input  logic [IDX_W-1:0] wb_rd,
   input  logic [W-1:0]     wb_data,
   output logic [W-1:0]     val
);

   // Pick the youngest in-flight producer of idx, else the register file.
   always_comb begin
      val = rf_val;
      if (idx != '0) begin
         if (iss_valid && iss_adv && (iss_rd == idx)) begin
            val = iss_val;
         end else if (wb_valid && (wb_rd == idx)) begin
            val = wb_data;
         end
      end
   end

endmodule

// File: rtl/alu_issue_wb_stage.sv
// Issue/writeback stage around an external combinational ALU.
// ISS drives the ALU operands; WB captures the ALU result for the
// register-file write port. One operation per cycle with forwarding.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Upstream holds its op while in_valid && !in_ready; WB holds its
// result while wb_valid && !wb_ready. in_ready is combinational (no skid).
module alu_issue_wb_stage
   import alu_pipe_pkg::*;
#(
   parameter int N     = ALU_N,
   parameter int RA_W  = ALU_RA_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       in_sel,
   input  logic [RA_W-1:0]  in_rd,
   input  logic [RA_W-1:0]  in_rs1_idx,
   input  logic [RA_W-1:0]  in_rs2_idx,
   input  logic [N-1:0]     in_rs1_val,
   input  logic [N-1:0]     in_rs2_val,
   input  logic             in_imm_en,
   input  logic [N-1:0]     in_imm,
   input  logic             flush,
   output logic [N-1:0]     alu_op1,
   output logic [N-1:0]     alu_op2,
   output logic [1:0]       alu_sel,
   input  logic [N-1:0]     alu_out,
   input  logic             alu_zero,
   output logic             wb_valid,
   input  logic             wb_ready,
   output logic [RA_W-1:0]  wb_rd,
   output logic [N-1:0]     wb_data,
   output logic             wb_zero,
   output logic [CNT_W-1:0] retire_cnt
);

   logic             iss_valid_q, iss_valid_d;
   iss_t             iss_q, iss_d;
   logic             wb_valid_q, wb_valid_d;
   logic [RA_W-1:0]  wb_rd_q, wb_rd_d;
   logic [N-1:0]     wb_data_q, wb_data_d;
   logic             wb_zero_q, wb_zero_d;
   logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

   logic         wb_adv, iss_adv, iss_to_wb, accept, wb_fire;
   logic [N-1:0] op1_fwd, op2_fwd, op2_sel;

   // Pipeline advance conditions and the upstream ready.
   always_comb begin
      wb_adv    = !wb_valid_q || wb_ready;
      iss_adv   = !iss_valid_q || wb_adv;
      in_ready  = iss_adv && !flush && !rst;
      accept    = in_valid && in_ready;
      iss_to_wb = iss_valid_q && wb_adv && !flush;
      wb_fire   = wb_valid_q && wb_ready;
   end

   fwd_sel #(.W(N), .IDX_W(RA_W)) u_fwd_rs1 (
      .idx       (in_rs1_idx),
      .rf_val    (in_rs1_val),
      .iss_valid (iss_valid_q),
      .iss_rd    (iss_q.rd),
      .iss_val   (alu_out),
      .iss_adv   (wb_adv && !flush),
      .wb_valid  (wb_valid_q),
      .wb_rd     (wb_rd_q),
      .wb_data   (wb_data_q),
      .val       (op1_fwd)
   );

   fwd_sel #(.W(N), .IDX_W(RA_W)) u_fwd_rs2 (
      .idx       (in_rs2_idx),
      .rf_val    (in_rs2_val),
      .iss_valid (iss_valid_q),
      .iss_rd    (iss_q.rd),
      .iss_val   (alu_out),
      .iss_adv   (wb_adv && !flush),
      .wb_valid  (wb_valid_q),
      .wb_rd     (wb_rd_q),
      .wb_data   (wb_data_q),
      .val       (op2_fwd)
   );

   // Immediate replaces the forwarded rs2 value entirely.
   always_comb begin
      op2_sel = in_imm_en ? in_imm : op2_fwd;
   end

   // Next-state for ISS and WB; everything holds unless an event moves it.
   always_comb begin
      iss_valid_d  = iss_valid_q;
      iss_d        = iss_q;
      wb_valid_d   = wb_valid_q;
      wb_rd_d      = wb_rd_q;
      wb_data_d    = wb_data_q;
      wb_zero_d    = wb_zero_q;
      retire_cnt_d = retire_cnt_q + {{(CNT_W-1){1'b0}}, wb_fire};

      if (accept) begin
         iss_valid_d = 1'b1;
         iss_d.sel   = in_sel;
         iss_d.rd    = in_rd;
         iss_d.op1   = op1_fwd;
         iss_d.op2   = op2_sel;
      end else if (flush || iss_to_wb) begin
         iss_valid_d = 1'b0;
      end

      if (iss_to_wb) begin
         wb_valid_d = 1'b1;
         wb_rd_d    = iss_q.rd;
         wb_data_d  = alu_out;
         wb_zero_d  = alu_zero;
      end else if (wb_fire) begin
         wb_valid_d = 1'b0;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         iss_valid_q  <= 1'b0;
         iss_q        <= '{sel: ALU_ADD, rd: '0, op1: '0, op2: '0};
         wb_valid_q   <= 1'b0;
         wb_rd_q      <= '0;
         wb_data_q    <= '0;
         wb_zero_q    <= 1'b0;
         retire_cnt_q <= '0;
      end else begin
         iss_valid_q  <= iss_valid_d;
         iss_q        <= iss_d;
         wb_valid_q   <= wb_valid_d;
         wb_rd_q      <= wb_rd_d;
         wb_data_q    <= wb_data_d;
         wb_zero_q    <= wb_zero_d;
         retire_cnt_q <= retire_cnt_d;
      end
   end

   // Output wiring.
   always_comb begin
      alu_op1    = iss_q.op1;
      alu_op2    = iss_q.op2;
      alu_sel    = iss_q.sel;
      wb_valid   = wb_valid_q;
      wb_rd      = wb_rd_q;
      wb_data    = wb_data_q;
      wb_zero    = wb_zero_q;
      retire_cnt = retire_cnt_q;
   end

endmodule

// File: tb/tb_alu_issue_wb_stage.sv
// Bench for alu_issue_wb_stage: a stand-in ALU, an architectural register
// model that executes ops in program order, and a scoreboard of expected
// writebacks.
module tb_alu_issue_wb_stage;

   localparam int N     = 32;
   localparam int RA_W  = 4;
   localparam int CNT_W = 16;
   localparam int EW    = RA_W + 1 + N;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_sel;
   logic [RA_W-1:0]  in_rd, in_rs1_idx, in_rs2_idx;
   logic [N-1:0]     in_rs1_val, in_rs2_val, in_imm;
   logic             in_imm_en;
   logic             flush;
   logic [N-1:0]     alu_op1, alu_op2, alu_out;
   logic [1:0]       alu_sel;
   logic             alu_zero;
   logic             wb_valid, wb_ready, wb_zero;
   logic [RA_W-1:0]  wb_rd;
   logic [N-1:0]     wb_data;
   logic [CNT_W-1:0] retire_cnt;

   alu_issue_wb_stage #(.N(N), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_sel     (in_sel),
      .in_rd      (in_rd),
      .in_rs1_idx (in_rs1_idx),
      .in_rs2_idx (in_rs2_idx),
      .in_rs1_val (in_rs1_val),
      .in_rs2_val (in_rs2_val),
      .in_imm_en  (in_imm_en),
      .in_imm     (in_imm),
      .flush      (flush),
      .alu_op1    (alu_op1),
      .alu_op2    (alu_op2),
      .alu_sel    (alu_sel),
      .alu_out    (alu_out),
      .alu_zero   (alu_zero),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_rd      (wb_rd),
      .wb_data    (wb_data),
      .wb_zero    (wb_zero),
      .retire_cnt (retire_cnt)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Stand-in for the external combinational ALU.
   always_comb begin
      case (alu_sel)
         2'b00:   alu_out = alu_op1 + alu_op2;
         2'b01:   alu_out = alu_op1 - alu_op2;
         2'b10:   alu_out = alu_op1 * alu_op2;
         default: alu_out = '0;
      endcase
   end
   assign alu_zero = (alu_out == '0);

   // ---------------- reference model / scoreboard ----------------
   int           checks = 0;
   int           errors = 0;
   logic [EW-1:0] exp_q[$];
   logic [N:0]   log_q[$];
   logic [N-1:0] rf[16];
   logic [N-1:0] arch[16];
   bit           in_iss;
   int unsigned  retired_n;
   int           undo_rd;
   logic [N-1:0] undo_val;
   bit           last_acc;
   logic         last_rdy_obs;
   logic [CNT_W-1:0] cnt_base;
   bit           saw_low;
   int           k, cyc;
   bit           pend;
   logic [1:0]   r_sel;
   int           r_rd, r_rs1, r_rs2;
   bit           r_ie;
   logic [N-1:0] r_imm;

   function automatic logic [N-1:0] alu_ref(input logic [1:0] s,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
      case (s)
         2'b00:   return a + b;
         2'b01:   return a - b;
         2'b10:   return a * b;
         default: return '0;
      endcase
   endfunction

   function automatic logic [N:0] log_at(input int i);
      if (i < log_q.size()) return log_q[i];
      return 'x;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_reg(input int i, input logic [N-1:0] v);
      rf[i]   = v;
      arch[i] = v;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_op(input logic [1:0] sel, input int rd, input int rs1,
                           input int rs2, input bit imm_en, input logic [N-1:0] imm);
      in_valid   = 1'b1;
      in_sel     = sel;
      in_rd      = RA_W'(rd);
      in_rs1_idx = RA_W'(rs1);
      in_rs2_idx = RA_W'(rs2);
      in_rs1_val = rf[rs1];
      in_rs2_val = rf[rs2];
      in_imm_en  = imm_en;
      in_imm     = imm;
   endtask

   // One clock: check handshake outputs mid-cycle, advance the model, and
   // return 1ns after the rising edge with the DUT settled.
   task automatic step();
      int            inflight;
      bit            wb_occ, exp_rdy, ret, mv;
      logic [EW-1:0] e;
      logic [N-1:0]  a, b, r;
      @(negedge clk);
      inflight = exp_q.size();
      wb_occ   = (inflight - int'(in_iss)) > 0;
      exp_rdy  = !rst && !flush && (inflight < 2 || wb_ready);
      last_rdy_obs = in_ready;
      chk("in_ready", in_ready, exp_rdy);
      if (!rst) chk("wb_valid", wb_valid, wb_occ);
      last_acc = in_valid && exp_rdy;
      ret      = !rst && wb_occ && wb_ready;
      if (!rst && wb_valid === 1'b1 && wb_ready) log_q.push_back({wb_zero, wb_data});
      if (ret) begin
         e = exp_q[0];
         chk("wb_rd", wb_rd, e[EW-1 -: RA_W]);
         chk("wb_data", wb_data, e[N-1:0]);
         chk("wb_zero", wb_zero, e[N]);
      end
      if (rst) begin
         exp_q.delete();
         in_iss    = 0;
         retired_n = 0;
         arch      = rf;
      end else begin
         if (ret) begin
            e = exp_q.pop_front();
            retired_n++;
            if (e[EW-1 -: RA_W] != 0) rf[e[EW-1 -: RA_W]] = e[N-1:0];
         end
         mv = in_iss && (!wb_occ || wb_ready) && !flush;
         if (flush && in_iss) begin
            void'(exp_q.pop_back());
            if (undo_rd != 0) arch[undo_rd] = undo_val;
            in_iss = 0;
         end else if (mv) begin
            in_iss = 0;
         end
         if (last_acc) begin
            a = (in_rs1_idx == 0) ? in_rs1_val : arch[in_rs1_idx];
            b = in_imm_en ? in_imm : ((in_rs2_idx == 0) ? in_rs2_val : arch[in_rs2_idx]);
            r = alu_ref(in_sel, a, b);
            exp_q.push_back({in_rd, (r == '0), r});
            undo_rd  = int'(in_rd);
            undo_val = arch[in_rd];
            if (in_rd != 0) arch[in_rd] = r;
            in_iss = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      flush    = 1'b0;
      wb_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
      chk("drain_wb_valid", wb_valid, 1'b0);
   endtask

   // ---------------- directed + random sequence ----------------
   initial begin
      for (int i = 0; i < 16; i++) begin rf[i] = '0; arch[i] = '0; end
      in_iss = 0; retired_n = 0; undo_rd = 0; undo_val = '0;
      rst = 1'b1; flush = 1'b0; wb_ready = 1'b1;
      drive_op(2'b00, 1, 0, 0, 1'b1, 32'd1);
      #1;
      step();
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("rst_wb_valid", wb_valid, 1'b0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", wb_rd, 0);
      chk("rst_wb_zero", wb_zero, 1'b0);
      chk("rst_alu_op1", alu_op1, 0);
      chk("rst_alu_op2", alu_op2, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_retire_cnt", retire_cnt, 0);
      step();
      step();

      // Single add: 5 + 7 -> r3
      set_reg(1, 32'd5); set_reg(2, 32'd7);
      drive_op(2'b00, 3, 1, 2, 1'b0, 32'd0);
      step();
      in_valid = 1'b0;
      chk("add_op1", alu_op1, 32'd5);
      chk("add_op2", alu_op2, 32'd7);
      chk("add_sel", alu_sel, 2'b00);
      step();
      chk("add_wb_valid", wb_valid, 1'b1);
      chk("add_wb_data", wb_data, 32'd12);
      chk("add_wb_rd", wb_rd, 3);
      chk("add_wb_zero", wb_zero, 1'b0);
      drain();

      // Back-to-back forwarding: r2 = 10-4; r6 = r2 * 3 with stale rs1 value
      set_reg(4, 32'd10); set_reg(5, 32'd4);
      log_q.delete();
      drive_op(2'b01, 2, 4, 5, 1'b0, 32'd0);
      step();
      drive_op(2'b10, 6, 2, 0, 1'b1, 32'd3);
      in_rs1_val = 32'd99;
      step();
      drain();
      chk("b2b_0", log_at(0), {1'b0, 32'd6});
      chk("b2b_1", log_at(1), {1'b0, 32'd18});

      // Distance-2 forwarding with an unrelated op in between
      log_q.delete();
      drive_op(2'b01, 7, 4, 5, 1'b0, 32'd0);
      step();
      drive_op(2'b00, 8, 4, 5, 1'b0, 32'd0);
      step();
      drive_op(2'b10, 9, 7, 0, 1'b1, 32'd3);
      in_rs1_val = 32'd99;
      step();
      drain();
      chk("dist2_mid", log_at(1), {1'b0, 32'd14});
      chk("dist2_res", log_at(2), {1'b0, 32'd18});

      // Index 0 is never forwarded
      log_q.delete();
      drive_op(2'b00, 0, 4, 5, 1'b0, 32'd0);
      step();
      drive_op(2'b00, 9, 0, 0, 1'b1, 32'd1);
      in_rs1_val = 32'd77;
      step();
      drain();
      chk("idx0_res", log_at(1), {1'b0, 32'd78});

      // Backpressure: 4 adds streamed with wb_ready low for 3 cycles
      log_q.delete();
      cnt_base = CNT_W'(retired_n);
      k = 1; cyc = 0; saw_low = 0;
      while (k <= 4 && cyc < 30) begin
         drive_op(2'b00, 9 + k, 0, 0, 1'b1, N'(k));
         wb_ready = (cyc >= 3);
         step();
         if (last_rdy_obs === 1'b0) saw_low = 1;
         if (last_acc) k++;
         cyc++;
      end
      drain();
      chk("bp_in_ready_dropped", saw_low, 1'b1);
      chk("bp_count", log_q.size(), 4);
      for (int i = 0; i < 4; i++) chk("bp_order", log_at(i), {1'b0, N'(i + 1)});
      chk("bp_retire_cnt", retire_cnt, cnt_base + 4);

      // Zero result and reserved select
      set_reg(15, 32'd9);
      log_q.delete();
      drive_op(2'b01, 14, 15, 15, 1'b0, 32'd0);
      step();
      drive_op(2'b11, 13, 1, 1, 1'b0, 32'd0);
      step();
      drain();
      chk("zero_sub", log_at(0), {1'b1, 32'd0});
      chk("zero_rsvd", log_at(1), {1'b1, 32'd0});

      // Flush with ISS and WB occupied under backpressure
      log_q.delete();
      cnt_base = CNT_W'(retired_n);
      wb_ready = 1'b0;
      drive_op(2'b00, 11, 0, 0, 1'b1, 32'd40);
      step();
      drive_op(2'b00, 12, 0, 0, 1'b1, 32'd50);
      step();
      drive_op(2'b00, 13, 0, 0, 1'b1, 32'd60);
      flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      step();
      step();
      drain();
      chk("flush_count", log_q.size(), 1);
      chk("flush_wb_op", log_at(0), {1'b0, 32'd40});
      chk("flush_retire_cnt", retire_cnt, cnt_base + 1);

      // Reset mid-stream
      wb_ready = 1'b1;
      drive_op(2'b00, 3, 0, 0, 1'b1, 32'd1);
      step();
      drive_op(2'b00, 4, 0, 0, 1'b1, 32'd2);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0; in_valid = 1'b0;
      chk("mid_rst_wb_valid", wb_valid, 1'b0);
      chk("mid_rst_wb_data", wb_data, 0);
      chk("mid_rst_wb_rd", wb_rd, 0);
      chk("mid_rst_wb_zero", wb_zero, 1'b0);
      chk("mid_rst_alu_op1", alu_op1, 0);
      chk("mid_rst_alu_op2", alu_op2, 0);
      chk("mid_rst_alu_sel", alu_sel, 0);
      chk("mid_rst_retire_cnt", retire_cnt, 0);
      step();
      step();

      // Randomized traffic over a small register pool to provoke hazards
      for (int i = 1; i < 6; i++) set_reg(i, $urandom);
      pend = 0;
      for (int c = 0; c < 400; c++) begin
         if (!pend && $urandom_range(0, 9) < 8) begin
            r_sel = 2'($urandom_range(0, 3));
            r_rd  = $urandom_range(0, 5);
            r_rs1 = $urandom_range(0, 5);
            r_rs2 = $urandom_range(0, 5);
            r_ie  = $urandom_range(0, 3) == 0;
            r_imm = $urandom;
            pend  = 1;
         end
         if (pend) drive_op(r_sel, r_rd, r_rs1, r_rs2, r_ie, r_imm);
         else in_valid = 1'b0;
         wb_ready = $urandom_range(0, 9) < 7;
         flush    = $urandom_range(0, 19) == 0;
         step();
         if (last_acc) pend = 0;
      end
      drain();
      chk("final_retire_cnt", retire_cnt, CNT_W'(retired_n));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue_wb_stage.md
Name: alu_issue_wb_stage

Overview:
- Pipeline stage that wraps the combinational ALU.
- Accepts decoded ALU operations over a valid/ready handshake and resolves register-operand hazards by forwarding.
- Drives operand1/operand2/sel into the ALU from an issue register (ISS), then captures out/zero into a writeback register (WB) that presents results to the register-file write port.
- Sits between decode/register-read and register-file writeback; sustains one operation per cycle.

Parameters:
- N, 32, datapath width; matches the ALU width.
- RA_W, 4, register index width.
- CNT_W, 16, retired-operation counter width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operation valid
- in_ready  out  1  stage can accept this cycle
- in_sel  in  2  ALU operation: 00 add, 01 sub, 10 mul, 11 reserved
- in_rd  in  RA_W  destination register index
- in_rs1_idx  in  RA_W  source-1 index
- in_rs2_idx  in  RA_W  source-2 index
- in_rs1_val  in  N  register-file value for rs1
- in_rs2_val  in  N  register-file value for rs2
- in_imm_en  in  1  operand2 taken from in_imm instead of rs2
- in_imm  in  N  immediate
- flush  in  1  discard the operation held in ISS
- alu_op1  out  N  to ALU operand1
- alu_op2  out  N  to ALU operand2
- alu_sel  out  2  to ALU sel
- alu_out  in  N  from ALU out
- alu_zero  in  1  from ALU zero
- wb_valid  out  1  result valid
- wb_ready  in  1  register file accepts the result
- wb_rd  out  RA_W  destination index
- wb_data  out  N  result
- wb_zero  out  1  zero flag of the result
- retire_cnt  out  CNT_W  count of WB handshakes; wraps modulo 2^CNT_W

Behaviour:
- Reset: all state is cleared, giving iss_valid=0, wb_valid=0, alu_op1=alu_op2=0, alu_sel=00, wb_rd=0, wb_data=0, wb_zero=0, retire_cnt=0.
- Advance conditions:
  - wb_adv = !wb_valid | wb_ready.
  - iss_adv = !iss_valid | wb_adv.
  - in_ready = iss_adv & !flush & !rst. This is a combinational path and contains no skid entry.
- Accept: in_valid & in_ready at edge k. The op occupies ISS during cycle k+1, when the ALU computes it. WB holds the result from cycle k+2. Minimum latency is 2 cycles.
- ISS to WB: when iss_valid & wb_adv, the stage loads wb_data=alu_out, wb_zero=alu_zero and wb_rd=iss_rd, and sets wb_valid=1.
- WB retire: when wb_valid & wb_ready and ISS does not refill WB, wb_valid goes to 0. Every WB handshake increments retire_cnt.
- Stall: when wb_valid & !wb_ready, WB and ISS hold all contents. alu_op1, alu_op2 and alu_sel stay stable.
- Forwarding is resolved at accept time, independently per source. For source s with index idx:
  - If idx==0, no forwarding; use the register-file value.
  - Else if iss_valid & iss_rd==idx & ISS advancing this cycle, use alu_out (newest producer wins).
  - Else if wb_valid & wb_rd==idx, use wb_data. This applies regardless of wb_ready and covers a same-cycle register-file write.
  - Otherwise use in_rsX_val.
- rs2 forwarding applies only when in_imm_en=0. With in_imm_en=1, op2=in_imm.
- Result-to-consumer forwarding distance of 1 and 2 therefore adds no bubble.
- in_sel=11: operation passes through normally; the ALU returns 0 and the zero flag is 1.
- flush:
  - Clears iss_valid on the next edge.
  - The ISS op does not reach WB. In the same cycle, WB does not load from ISS.
  - WB contents are unaffected and still retire.
  - The upstream op is not accepted that cycle (in_ready=0).
- Simultaneous events:
  - Accept, ISS-to-WB and WB-retire can all happen in one edge.
  - rst overrides flush and all handshakes.
  - Reset mid-operation drops all in-flight ops with no wb_valid pulse.
- Arithmetic is performed entirely in the ALU; this stage performs no width changes. Values are N bits, and mul is the truncated low N bits.

Decomposition:
- Package alu_pipe_pkg holds:
  - localparams ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_MUL=2'b10, ALU_RSVD=2'b11.
  - A packed struct iss_t {sel, rd, op1, op2}.
- Sub-module fwd_sel: a parameterised forwarding comparator/mux, instantiated once per source. Inputs are idx, rf value, ISS producer (valid, rd, alu_out, adv) and WB producer (valid, rd, data); output is the selected value.
- The ALU itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset: hold rst 2 cycles with in_valid=1 -> in_ready=0 during reset; afterwards in_ready=1, wb_valid=0, retire_cnt=0, no spurious wb_valid.
- Single add: rs1_val=5, rs2_val=7, sel=00, rd=3 at cycle 0 -> alu_op1=5, alu_op2=7 in cycle 1; wb_valid=1, wb_data=12, wb_rd=3, wb_zero=0 in cycle 2.
- Forwarding:
  - Back-to-back: I1 rd=2, 10-4. I2 rs1_idx=2 with stale rs1_val=99, imm_en=1, imm=3, sel=10. Expect wb_data sequence 6, 18.
  - Distance 2: insert an unrelated op between them -> still 18.
  - Index 0: use rd=0, rs1_idx=0 -> stale value used, no forwarding.
- Backpressure: wb_ready=0 for 3 cycles while streaming 4 adds (results 1,2,3,4) -> in_ready drops once ISS and WB are full; results retire in order 1,2,3,4 with no loss or duplication; retire_cnt=4.
- Zero/reserved: 9-9 -> wb_data=0, wb_zero=1; sel=11 with 5,5 -> wb_data=0, wb_zero=1.
- Flush and reset:
  - Flush with ISS and WB occupied and wb_ready=0 -> ISS op never appears; WB op retires once when wb_ready=1; retire_cnt advances by 1.
  - Assert rst mid-stream -> all outputs return to reset values the next cycle.
